vga_fb_fetch: RTL and testbench
===============================

Name: vga_fb_fetch

Overview:
- DDR-side writer feeding the VGA pixel data FIFO.
- Issues Avalon-MM burst reads over a linear framebuffer in DDR and pushes every 128-bit returned word (4 pixels of 32 bits, pixel 0 in [31:0], byte 0=R, 1=G, 2=B) into the data FIFO.
- Throttles requests by FIFO fill level plus words still in flight, so the FIFO never overflows.
- Wraps to the framebuffer base at end of frame, continuously.

Parameters:
- FB_BASE, 32'h0000_0000, byte address of framebuffer; 16-byte aligned.
- FRAME_WORDS, 76800, 128-bit words per frame (640x480/4); multiple of BURST_LEN.
- BURST_LEN, 8, words per Avalon burst; 1..64.
- FIFO_DEPTH, 512, data FIFO capacity in words.
- USED_W, 10, width of FIFO fill-level input; must hold FIFO_DEPTH.

Ports:
- ddr_clk  in  1  single clock for all logic.
- ddr_reset_n  in  1  reset; synchronous, active-low.
- enable  in  1  level; fetching allowed while high.
- avm_address  out  32  byte address of burst.
- avm_read  out  1  read command request.
- avm_burstcount  out  7  always BURST_LEN.
- avm_waitrequest  in  1  command stall.
- avm_readdata  in  128  return data.
- avm_readdatavalid  in  1  return data valid.
- ddr_fifo_wr_data  out  128  FIFO write data.
- ddr_fifo_wr_en  out  1  FIFO write strobe.
- ddr_fifo_used  in  USED_W  FIFO fill level, writes not yet reflected allowed.
- frame_done  out  1  one-cycle pulse when the last word of a frame is written.
- busy  out  1  high while any command is pending or data is outstanding.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset (ddr_reset_n low at a ddr_clk edge): state=IDLE, word_idx=0, inflight=0, ret_idx=0, and all outputs 0.
- Reset mid-burst abandons in-flight data. Returns arriving after reset are ignored; system resets DDR side together.
- State IDLE: avm_read=0.
  - Go to ISSUE when enable=1 and credit_ok.
  - credit_ok = ddr_fifo_used + inflight + BURST_LEN <= FIFO_DEPTH, computed at USED_W+1 bits with no truncation.
- State ISSUE: avm_read=1, avm_address=FB_BASE + word_idx*16, avm_burstcount=BURST_LEN.
  - All three are held stable while avm_waitrequest=1.
  - Command is accepted on a cycle with avm_read=1 and avm_waitrequest=0.
  - On acceptance: inflight += BURST_LEN, and word_idx += BURST_LEN; word_idx wraps to 0 when it reaches FRAME_WORDS.
  - Next state is ISSUE again (back-to-back, no bubble) if enable=1 and credit_ok holds using the updated inflight. Otherwise IDLE.
  - Command is never withdrawn once asserted, even if enable drops.
- Return path is independent of state:
  - Each avm_readdatavalid=1 cycle registers avm_readdata to ddr_fifo_wr_data with ddr_fifo_wr_en=1 on the next cycle (latency 1), and decrements inflight.
  - If accept and return occur in the same cycle: inflight += BURST_LEN-1.
- ret_idx counts written words and wraps at FRAME_WORDS.
  - frame_done pulses in the same cycle as the wr_en of word FRAME_WORDS-1.
- overflow sets if a write occurs while ddr_fifo_used >= FIFO_DEPTH. Cleared only by reset.
- enable low: no new commands; in-flight data still drains to FIFO. word_idx/ret_idx are kept.
- Re-enable after drain resumes at word_idx; it does not restart the frame.
- busy = (state==ISSUE) | (inflight!=0) | ddr_fifo_wr_en.
- inflight width: clog2(FIFO_DEPTH)+1; never exceeds FIFO_DEPTH by construction.

Test Plan:
- Basic fetch, bench params FRAME_WORDS=32, BURST_LEN=8, FIFO_DEPTH=16, FB_BASE=0x1000; enable=1, used=0, no wait, readdata=index -> avm_address 0x1000, 0x1080; third command blocked until used drops; FIFO receives words 0..7 in order, each one cycle after its valid.
- Waitrequest stall: waitrequest=1 for 5 cycles on the first command -> avm_read, avm_address=0x1000, burstcount=8 stable all 5 cycles; exactly one accept counted.
- Frame wrap: drain FIFO continuously for 40 words -> commands at 0x1000, 0x1080, 0x1100, 0x1180, then 0x1000; frame_done single pulse with wr_en of word 31.
- Credit limit: hold used=9 with inflight=0 -> no command (9+0+8>16); set used=8 -> command issued next cycle.
- Enable drop mid-burst: deassert enable after accept of burst at 0x1080 -> all 8 words still written, no new command, busy falls after last wr_en; re-enable -> next address 0x1100.
- Reset mid-operation and overflow: force a write with used=16 -> overflow=1 and stays 1; assert ddr_reset_n=0 for one edge -> all outputs 0, next command at 0x1000.

Source files
------------

// File: rtl/vga_fb_fetch.sv
// vga_fb_fetch
// -----------------------------------------------------------------------------
// Reads a linear framebuffer out of DDR with Avalon-MM burst reads and writes
// every returned 128-bit word (four 32-bit pixels, pixel 0 in [31:0]) into the
// VGA pixel data FIFO. New bursts are only requested when the FIFO is
// guaranteed room for them, counting both its current fill level and the words
// already requested but not yet returned. The read pointer wraps to the
// framebuffer base at the end of each frame and fetching is continuous.
//
// Ports
//   ddr_clk, ddr_reset_n  : clock, synchronous active-low reset
//   enable                : level, new bursts may be requested while high
//   avm_*                 : Avalon-MM burst read master (command + return)
//   ddr_fifo_wr_data/en   : FIFO write side, one word per returned beat
//   ddr_fifo_used         : FIFO fill level (may lag recent writes)
//   frame_done            : pulse with the write of the last word of a frame
//   busy                  : command pending, data outstanding or write active
//   overflow              : sticky, a write happened while the FIFO was full
//
// Handshake: a command is accepted on any cycle where avm_read=1 and
// avm_waitrequest=0; address/read/burstcount do not change while stalled and
// an asserted command is never withdrawn. Each avm_readdatavalid beat is
// written to the FIFO exactly one cycle later.
// -----------------------------------------------------------------------------
module vga_fb_fetch #(
    parameter logic [31:0] FB_BASE     = 32'h0000_0000,
    parameter int          FRAME_WORDS = 76800,
    parameter int          BURST_LEN   = 8,
    parameter int          FIFO_DEPTH  = 512,
    parameter int          USED_W      = 10
) (
    input  logic              ddr_clk,
    input  logic              ddr_reset_n,
    input  logic              enable,
    output logic [31:0]       avm_address,
    output logic              avm_read,
    output logic [6:0]        avm_burstcount,
    input  logic              avm_waitrequest,
    input  logic [127:0]      avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [127:0]      ddr_fifo_wr_data,
    output logic              ddr_fifo_wr_en,
    input  logic [USED_W-1:0] ddr_fifo_used,
    output logic              frame_done,
    output logic              busy,
    output logic              overflow
);
    localparam int INF_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = $clog2(FRAME_WORDS + 1);

    localparam logic [INF_W-1:0] BURST_INF = INF_W'(BURST_LEN);
    localparam logic [INF_W-1:0] ONE_INF   = INF_W'(1);
    localparam logic [31:0]      BURST_U   = 32'(BURST_LEN);
    localparam logic [31:0]      DEPTH_U   = 32'(FIFO_DEPTH);
    localparam logic [31:0]      FRAME_U   = 32'(FRAME_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_WORDS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] word_idx_nxt;
    logic [IDX_W-1:0] ret_idx;
    logic [INF_W-1:0] inflight;
    logic [INF_W-1:0] inflight_nxt;
    logic             accept;
    logic             ret_ok;
    logic             credit_now;
    logic             credit_nxt;
    logic [31:0]      widx_sum;

    always_comb begin
        accept = (state == ISSUE) && avm_read && !avm_waitrequest;
        // With nothing outstanding a return beat can only be stale data from
        // before a reset, so it is dropped instead of written.
        ret_ok = avm_readdatavalid && (inflight != '0);

        inflight_nxt = inflight;
        if (accept) begin
            inflight_nxt = inflight_nxt + BURST_INF;
        end
        if (ret_ok) begin
            inflight_nxt = inflight_nxt - ONE_INF;
        end

        widx_sum     = 32'(word_idx) + BURST_U;
        word_idx_nxt = word_idx;
        if (accept) begin
            word_idx_nxt = (widx_sum >= FRAME_U) ? '0 : widx_sum[IDX_W-1:0];
        end

        // Summed at 32 bits so the comparison can never wrap.
        credit_now = (32'(ddr_fifo_used) + 32'(inflight) + BURST_U) <= DEPTH_U;
        credit_nxt = (32'(ddr_fifo_used) + 32'(inflight_nxt) + BURST_U) <= DEPTH_U;
    end

    assign busy = (state == ISSUE) | (inflight != '0) | ddr_fifo_wr_en;

    always_ff @(posedge ddr_clk) begin
        if (!ddr_reset_n) begin
            state            <= IDLE;
            word_idx         <= '0;
            ret_idx          <= '0;
            inflight         <= '0;
            avm_read         <= 1'b0;
            avm_address      <= '0;
            avm_burstcount   <= '0;
            ddr_fifo_wr_data <= '0;
            ddr_fifo_wr_en   <= 1'b0;
            frame_done       <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            word_idx       <= word_idx_nxt;
            inflight       <= inflight_nxt;
            avm_burstcount <= 7'(BURST_LEN);
            // Tracks the next burst address; word_idx only moves on accept,
            // so the address is stable for the whole of a stall.
            avm_address    <= FB_BASE + (32'(word_idx_nxt) << 4);

            if (state == IDLE) begin
                if (enable && credit_now) begin
                    state    <= ISSUE;
                    avm_read <= 1'b1;
                end
            end else if (accept) begin
                // Back-to-back issue is judged on the post-accept inflight.
                if (enable && credit_nxt) begin
                    state    <= ISSUE;
                    avm_read <= 1'b1;
                end else begin
                    state    <= IDLE;
                    avm_read <= 1'b0;
                end
            end

            ddr_fifo_wr_en <= ret_ok;
            frame_done     <= ret_ok && (ret_idx == LAST_IDX);
            if (ret_ok) begin
                ddr_fifo_wr_data <= avm_readdata;
                ret_idx          <= (ret_idx == LAST_IDX) ? '0 : ret_idx + ONE_IDX;
            end

            if (ddr_fifo_wr_en && (32'(ddr_fifo_used) >= DEPTH_U)) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vga_fb_fetch.sv
// tb_vga_fb_fetch
// Directed bench for vga_fb_fetch with a small frame (32 words, bursts of 8,
// 16-word FIFO, base 0x1000). A table of per-cycle vectors covers reset,
// credit gating and a waitrequest stall; hand sequences cover frame wrap,
// enable drop/resume, overflow and reset with data in flight. A DDR model
// returns mk_data(word index) for every accepted burst; a monitor checks
// addresses, write latency, data order and frame_done every cycle.
module tb_vga_fb_fetch;
    localparam logic [31:0] FB = 32'h0000_1000;

    logic         clk = 1'b0;
    logic         ddr_reset_n = 1'b0;
    logic         enable = 1'b0;
    logic [31:0]  avm_address;
    logic         avm_read;
    logic [6:0]   avm_burstcount;
    logic         avm_waitrequest = 1'b0;
    logic [127:0] avm_readdata = '0;
    logic         avm_readdatavalid = 1'b0;
    logic [127:0] ddr_fifo_wr_data;
    logic         ddr_fifo_wr_en;
    logic [4:0]   ddr_fifo_used = '0;
    logic         frame_done;
    logic         busy;
    logic         overflow;

    vga_fb_fetch #(
        .FB_BASE(FB), .FRAME_WORDS(32), .BURST_LEN(8), .FIFO_DEPTH(16), .USED_W(5)
    ) dut (
        .ddr_clk(clk), .ddr_reset_n(ddr_reset_n), .enable(enable),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .ddr_fifo_wr_data(ddr_fifo_wr_data), .ddr_fifo_wr_en(ddr_fifo_wr_en),
        .ddr_fifo_used(ddr_fifo_used), .frame_done(frame_done),
        .busy(busy), .overflow(overflow)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    logic         ret_en   = 1'b0;
    logic         mon_on   = 1'b0;
    logic [127:0] exp_q[$];
    logic [127:0] pend_q[$];
    int           ret_model = 0;
    int           wr_cnt    = 0;
    int           fd_cnt    = 0;
    int           acc_k     = 0;
    int           acc_cnt   = 0;
    logic         prev_rdv  = 1'b0;
    logic [31:0]  last_addr = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_data(input int unsigned idx);
        return {32'hC0DE_0000 | idx, 32'hBEEF_0000 | idx, 32'h0012_0000 | idx, idx};
    endfunction

    // ---------------- DDR return model ----------------
    initial forever begin
        @(posedge clk);
        #1;
        if (ret_en && pend_q.size() > 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend_q.pop_front();
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = '0;
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        logic [127:0] e;
        int unsigned  base;
        @(negedge clk);
        #1;
        if (mon_on) begin
            check("wr_latency", 128'(ddr_fifo_wr_en), 128'(prev_rdv));
            check("frame_done", 128'(frame_done), 128'(ddr_fifo_wr_en && (ret_model == 31)));
            if (ddr_fifo_wr_en) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("wr_data_q", ddr_fifo_wr_data, e);
                end
                check("wr_data_order", ddr_fifo_wr_data, mk_data(ret_model));
                ret_model = (ret_model == 31) ? 0 : ret_model + 1;
                wr_cnt++;
                if (frame_done) fd_cnt++;
            end
            if (!ddr_reset_n) begin
                ret_model = 0;
                acc_k     = 0;
                prev_rdv  = 1'b0;
                exp_q.delete();
                pend_q.delete();
            end else begin
                prev_rdv = avm_readdatavalid;
                if (avm_readdatavalid) exp_q.push_back(avm_readdata);
                if (avm_read && !avm_waitrequest) begin
                    check("accept_addr", 128'(avm_address), 128'(FB + (32'(acc_k * 8) << 4)));
                    check("accept_bc", 128'(avm_burstcount), 128'(8));
                    last_addr = avm_address;
                    acc_k     = (acc_k + 1) % 4;
                    acc_cnt++;
                    base = (avm_address - FB) >> 4;
                    for (int b = 0; b < 8; b++) pend_q.push_back(mk_data(base + b));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_read(input string tag);
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (avm_read) found = 1;
        end
        check(tag, 128'(found), 128'(1));
    endtask

    task automatic drain(input string tag);
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!busy && pend_q.size() == 0 && !avm_readdatavalid) done = 1;
        end
        check(tag, 128'(done), 128'(1));
        @(negedge clk);
        check({tag, "_read"}, 128'(avm_read), 128'(0));
    endtask

    // Issue exactly one burst: the command is accepted on the cycle enable
    // falls, so no back-to-back follow-up is requested.
    task automatic single_burst(input string tag);
        ret_en = 1'b0; avm_waitrequest = 1'b1; enable = 1'b1;
        wait_read({tag, "_req"});
        enable = 1'b0; avm_waitrequest = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, 128'(avm_read), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(1));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst_n;
        logic        en;
        logic [4:0]  used;
        logic        wr;
        logic        exp_read;
        logic [31:0] exp_addr;
        logic [6:0]  exp_bc;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int base_acc;
        int base_wr;
        bit found;

        vecs[0]  = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000, 7'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000, 7'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h1000, 7'd8, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 32'h1000, 7'd8, 1'b0}; // 9+0+8>16
        vecs[4]  = '{1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 32'h1000, 7'd8, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 32'h1000, 7'd8, 1'b1}; // 8+0+8=16
        for (int i = 6; i <= 10; i++)
            vecs[i] = '{1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 32'h1000, 7'd8, 1'b1}; // stall
        vecs[11] = '{1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 32'h1080, 7'd8, 1'b1}; // accept, back-to-back
        vecs[12] = '{1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 32'h1100, 7'd8, 1'b1}; // accept, 0+16+8>16
        vecs[13] = '{1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 32'h1100, 7'd8, 1'b1};

        for (int i = 0; i < 14; i++) begin
            ddr_reset_n     = vecs[i].rst_n;
            enable          = vecs[i].en;
            ddr_fifo_used   = vecs[i].used;
            avm_waitrequest = vecs[i].wr;
            if (i == 2) mon_on = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d_read", i), 128'(avm_read), 128'(vecs[i].exp_read));
            check($sformatf("vec%0d_addr", i), 128'(avm_address), 128'(vecs[i].exp_addr));
            check($sformatf("vec%0d_bc", i), 128'(avm_burstcount), 128'(vecs[i].exp_bc));
            check($sformatf("vec%0d_busy", i), 128'(busy), 128'(vecs[i].exp_busy));
            check($sformatf("vec%0d_wr_en", i), 128'(ddr_fifo_wr_en), 128'(0));
            check($sformatf("vec%0d_ovf", i), 128'(overflow), 128'(0));
        end
        check("stall_accepts", 128'(acc_cnt), 128'(2));

        // Continuous drain through a frame wrap.
        ret_en = 1'b1;
        found  = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (wr_cnt >= 40) found = 1;
        end
        check("wrap_40_words", 128'(found), 128'(1));
        enable = 1'b0;
        check("wrap_accepts", 128'(acc_cnt >= 5), 128'(1));
        drain("wrap_drain");
        check("wrap_frame_done", 128'(fd_cnt), 128'(1));
        check("wrap_no_ovf", 128'(overflow), 128'(0));

        // Enable dropped on the accept cycle: one burst drains, nothing new.
        base_acc = acc_cnt;
        single_burst("endrop");
        base_wr = wr_cnt;
        ret_en  = 1'b1;
        repeat (20) @(negedge clk);
        check("endrop_accepts", 128'(acc_cnt), 128'(base_acc + 1));
        check("endrop_words", 128'(wr_cnt), 128'(base_wr + 8));
        check("endrop_busy", 128'(busy), 128'(0));
        check("endrop_read", 128'(avm_read), 128'(0));

        // Re-enable resumes from the kept word index (checked by the monitor).
        base_acc = acc_cnt;
        enable   = 1'b1;
        found    = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (acc_cnt > base_acc) found = 1;
        end
        enable = 1'b0;
        check("resume_accept", 128'(found), 128'(1));
        drain("resume_drain");

        // Write while FIFO full, then reset with data still outstanding.
        single_burst("ovf");
        ddr_fifo_used = 5'd16;
        ret_en        = 1'b1;
        found         = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (overflow) found = 1;
        end
        ret_en = 1'b0;
        check("ovf_set", 128'(found), 128'(1));
        repeat (2) @(negedge clk);
        check("ovf_sticky", 128'(overflow), 128'(1));
        check("ovf_inflight_busy", 128'(busy), 128'(1));

        ddr_reset_n   = 1'b0;
        ddr_fifo_used = 5'd0;
        @(negedge clk);
        check("rst_read", 128'(avm_read), 128'(0));
        check("rst_addr", 128'(avm_address), 128'(0));
        check("rst_bc", 128'(avm_burstcount), 128'(0));
        check("rst_wr_en", 128'(ddr_fifo_wr_en), 128'(0));
        check("rst_wr_data", ddr_fifo_wr_data, 128'(0));
        check("rst_frame_done", 128'(frame_done), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_ovf", 128'(overflow), 128'(0));

        ddr_reset_n = 1'b1;
        ret_en      = 1'b1;
        enable      = 1'b1;
        base_acc    = acc_cnt;
        found       = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (acc_cnt > base_acc) found = 1;
        end
        enable = 1'b0;
        check("post_rst_accept", 128'(found), 128'(1));
        check("post_rst_addr", 128'(last_addr), 128'(32'h1000));
        drain("post_rst_drain");
        check("post_rst_ovf", 128'(overflow), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
